// File: rtl/dmem_pkg.sv
// Shared types and helpers for the RV32 data memory / load-store unit.
package dmem_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_X} size_e;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  // Access fault: illegal size, or address not aligned to the access size.
  function automatic logic misaligned(size_e size, logic [1:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response port of the data memory load-store unit.
interface dmem_lsu_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_align.sv
// Combinational lane steering: store lane mask / replicated data, load extract / extend.
module dmem_align
  import dmem_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  off,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  lane_mask,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;
  logic [15:0] half;

  // Select lanes and extend the loaded byte/half to 32 bits.
  always_comb begin
    lane_mask = '0;
    wdata_rep = '0;
    rdata_ext = '0;
    shifted   = rword >> {off, 3'b000};
    half      = off[1] ? rword[31:16] : rword[15:0];
    case (size)
      SZ_B: begin
        lane_mask = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = is_unsigned ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        lane_mask = off[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = is_unsigned ? {16'h0, half} : {{16{half[15]}}, half};
      end
      SZ_W: begin
        lane_mask = '1;
        wdata_rep = wdata;
        rdata_ext = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// RV32 data memory with load/store front end, valid/ready request and wait states.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 1
) (
  input logic       clk,
  input logic       rst,
  dmem_lsu_if.slave bus
);

  localparam int         DEPTH    = 2 ** (ADDR_W - 2);
  localparam logic [3:0] CNT_INIT = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              accept, enter_resp;

  logic              q_we, q_unsigned;
  size_e             q_size;
  logic [ADDR_W-1:0] q_addr;
  logic [31:0]       q_wdata;

  logic              a_we, a_unsigned;
  size_e             a_size;
  logic [ADDR_W-1:0] a_addr;
  logic [31:0]       a_wdata;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [ADDR_W-3:0] word_idx;
  logic              fault;
  logic [3:0]        lane_mask;
  logic [31:0]       wdata_rep, rdata_ext;

  // State and wait counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter and handshake decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (WAIT_CYC == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the request fields on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      q_we       <= bus.req_we;
      q_size     <= size_e'(bus.req_size);
      q_unsigned <= bus.req_unsigned;
      q_addr     <= bus.req_addr;
      q_wdata    <= bus.req_wdata;
    end
  end

  // Access operands: with no wait states the array is touched on the accept
  // edge itself, so the live request is used instead of the capture register.
  always_comb begin
    a_we       = q_we;
    a_size     = q_size;
    a_unsigned = q_unsigned;
    a_addr     = q_addr;
    a_wdata    = q_wdata;
    if (state_q == IDLE) begin
      a_we       = bus.req_we;
      a_size     = size_e'(bus.req_size);
      a_unsigned = bus.req_unsigned;
      a_addr     = bus.req_addr;
      a_wdata    = bus.req_wdata;
    end
    word_idx = a_addr[ADDR_W-1:2];
    fault    = misaligned(a_size, a_addr[1:0]);
  end

  dmem_align u_align (
    .size        (a_size),
    .off         (a_addr[1:0]),
    .is_unsigned (a_unsigned),
    .wdata       (a_wdata),
    .rword       (mem[word_idx]),
    .lane_mask   (lane_mask),
    .wdata_rep   (wdata_rep),
    .rdata_ext   (rdata_ext)
  );

  // Word array and response registers; reset clears the whole array.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (enter_resp) begin
      err_q <= fault;
      if (a_we) begin
        rdata_q <= '0;
        if (!fault) begin
          for (int unsigned i = 0; i < 4; i++)
            if (lane_mask[i]) mem[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
        end
      end else begin
        rdata_q <= fault ? '0 : rdata_ext;
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: WAIT_CYC=1 instance (a) and WAIT_CYC=0 instance (b).
module tb_dmem_lsu;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   acc, pulses;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_lsu_if #(.ADDR_W(10)) bus_a ();
  dmem_lsu_if #(.ADDR_W(10)) bus_b ();

  dmem_lsu #(.ADDR_W(10), .WAIT_CYC(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  dmem_lsu #(.ADDR_W(10), .WAIT_CYC(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for instance a: pop and compare on every response strobe.
  always @(negedge clk) begin
    if (bus_a.rsp_valid === 1'b1) begin
      if (qa.size() == 0) chk("a_unexpected_rsp", 32'd1, 32'd0);
      else begin
        ea = qa.pop_front();
        chk("a_rdata", bus_a.rsp_rdata, ea.rdata);
        chk("a_err", {31'd0, bus_a.rsp_err}, {31'd0, ea.err});
        chk("a_latency", cyc, ea.due);
      end
    end
  end

  // Monitor for instance b.
  always @(negedge clk) begin
    if (bus_b.rsp_valid === 1'b1) begin
      if (qb.size() == 0) chk("b_unexpected_rsp", 32'd1, 32'd0);
      else begin
        eb = qb.pop_front();
        chk("b_rdata", bus_b.rsp_rdata, eb.rdata);
        chk("b_err", {31'd0, bus_b.rsp_err}, {31'd0, eb.err});
        chk("b_latency", cyc, eb.due);
      end
    end
  end

  // One request to instance a; expected response pushed at issue time.
  task automatic do_a(input logic we, input logic [1:0] size, input logic uns,
                      input logic [9:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (bus_a.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      chk("a_ready_timeout", 32'd0, 32'd1);
      return;
    end
    bus_a.req_valid    = 1'b1;
    bus_a.req_we       = we;
    bus_a.req_size     = size;
    bus_a.req_unsigned = uns;
    bus_a.req_addr     = addr;
    bus_a.req_wdata    = wdata;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.due   = cyc + 2;
    qa.push_back(e);
    @(negedge clk);
    bus_a.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) chk("drain_timeout", qa.size() + qb.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_size = 2'd0;
    bus_a.req_unsigned = 1'b0; bus_a.req_addr = '0; bus_a.req_wdata = '0;
    bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_size = 2'd0;
    bus_b.req_unsigned = 1'b0; bus_b.req_addr = '0; bus_b.req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, bus_a.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, bus_a.rsp_valid}, 32'd0);
    chk("rst_rdata", bus_a.rsp_rdata, 32'd0);
    chk("rst_err", {31'd0, bus_a.rsp_err}, 32'd0);
    rst = 1'b0;

    // Word store then load.
    do_a(1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF, 32'h0, 1'b0);
    do_a(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0);

    // Byte lane store, then extended loads.
    do_a(1'b1, 2'd0, 1'b0, 10'h013, 32'hAAAAAA80, 32'h0, 1'b0);
    do_a(1'b0, 2'd0, 1'b0, 10'h013, 32'h0, 32'hFFFFFF80, 1'b0);
    do_a(1'b0, 2'd0, 1'b1, 10'h013, 32'h0, 32'h00000080, 1'b0);
    do_a(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 32'h80ADBEEF, 1'b0);
    do_a(1'b0, 2'd1, 1'b0, 10'h012, 32'h0, 32'hFFFF80AD, 1'b0);
    do_a(1'b0, 2'd1, 1'b1, 10'h010, 32'h0, 32'h0000BEEF, 1'b0);
    do_a(1'b0, 2'd0, 1'b0, 10'h011, 32'h0, 32'hFFFFFFBE, 1'b0);

    // Faults and an aligned upper-half store.
    do_a(1'b1, 2'd1, 1'b0, 10'h011, 32'h00001234, 32'h0, 1'b1);
    do_a(1'b0, 2'd3, 1'b0, 10'h000, 32'h0, 32'h0, 1'b1);
    do_a(1'b1, 2'd2, 1'b0, 10'h012, 32'hFFFFFFFF, 32'h0, 1'b1);
    do_a(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 32'h80ADBEEF, 1'b0);
    do_a(1'b1, 2'd1, 1'b0, 10'h016, 32'h12345A5A, 32'h0, 1'b0);
    do_a(1'b0, 2'd2, 1'b0, 10'h014, 32'h0, 32'h5A5A0000, 1'b0);
    drain();

    // req_valid held for 10 cycles starting in WAIT of a prior load.
    do_a(1'b0, 2'd2, 1'b0, 10'h000, 32'h0, 32'h0, 1'b0);
    acc = 0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      bus_a.req_valid = 1'b1;
      bus_a.req_we    = 1'b0;
      bus_a.req_size  = 2'd2;
      bus_a.req_addr  = 10'(8 + 4 * i);
      chk("hold_ready", {31'd0, bus_a.req_ready}, (i % 3 == 2) ? 32'd1 : 32'd0);
      if (bus_a.req_ready === 1'b1) begin
        acc++;
        e.rdata = (bus_a.req_addr == 10'h010) ? 32'h80ADBEEF : 32'h0;
        e.err   = 1'b0;
        e.due   = cyc + 2;
        qa.push_back(e);
      end
      if (bus_a.rsp_valid === 1'b1) pulses++;
      @(negedge clk);
    end
    bus_a.req_valid = 1'b0;
    chk("hold_accepts", acc, 32'd3);
    chk("hold_pulses", pulses, 32'd3);
    drain();
    do_a(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 32'h80ADBEEF, 1'b0);
    drain();

    // Reset during WAIT of a store: dropped, array cleared.
    bus_a.req_valid = 1'b1; bus_a.req_we = 1'b1; bus_a.req_size = 2'd2;
    bus_a.req_addr = 10'h3FC; bus_a.req_wdata = 32'h0000FFFF;
    chk("rst5_ready_before", {31'd0, bus_a.req_ready}, 32'd1);
    @(negedge clk);
    bus_a.req_valid = 1'b0;
    chk("rst5_in_wait", {31'd0, bus_a.req_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst5_ready", {31'd0, bus_a.req_ready}, 32'd1);
    chk("rst5_rdata", bus_a.rsp_rdata, 32'd0);
    chk("rst5_err", {31'd0, bus_a.rsp_err}, 32'd0);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus_a.rsp_valid === 1'b1) pulses++;
      @(negedge clk);
    end
    chk("rst5_no_rsp", pulses, 32'd0);
    do_a(1'b0, 2'd2, 1'b0, 10'h3FC, 32'h0, 32'h0, 1'b0);
    do_a(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 32'h0, 1'b0);
    drain();

    // Zero wait states on instance b.
    bus_b.req_valid = 1'b1; bus_b.req_we = 1'b1; bus_b.req_size = 2'd2;
    bus_b.req_unsigned = 1'b0; bus_b.req_addr = 10'h004; bus_b.req_wdata = 32'hCAFEF00D;
    chk("b_ready_idle", {31'd0, bus_b.req_ready}, 32'd1);
    e.rdata = 32'h0; e.err = 1'b0; e.due = cyc + 1;
    qb.push_back(e);
    @(negedge clk);
    bus_b.req_valid = 1'b0;
    chk("b_ready_resp", {31'd0, bus_b.req_ready}, 32'd0);
    @(negedge clk);
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      bus_b.req_valid = 1'b1;
      bus_b.req_we    = 1'b0;
      bus_b.req_addr  = (i < 2) ? 10'h000 : 10'h004;
      chk("b_ready_pattern", {31'd0, bus_b.req_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      if (bus_b.req_ready === 1'b1) begin
        acc++;
        e.rdata = (bus_b.req_addr == 10'h004) ? 32'hCAFEF00D : 32'h0;
        e.err   = 1'b0;
        e.due   = cyc + 1;
        qb.push_back(e);
      end
      @(negedge clk);
    end
    bus_b.req_valid = 1'b0;
    chk("b_accepts", acc, 32'd2);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
